accel_avg_filter: RTL and testbench
===================================

// Module: accel_avg_filter
// PURPOSE
//  Multi-channel moving-average filter for raw accelerometer samples; feeds the platform filter_x/y/z_export inputs.
//  Accepts one packed NUM_CH-channel sample per valid/ready handshake and processes channels serially, one per cycle,
//  through a shared adder. Emits a packed per-channel mean over the last 2^LOG2_DEPTH samples.
//  Per-sample bypass returns raw data; flush restarts the window.
// PARAMETERS
//  NUM_CH      3   number of channels (x,y,z), >=1
//  DATA_W      16  signed sample width per channel
//  LOG2_DEPTH  3   log2 of window length (DEPTH = 2^LOG2_DEPTH = 8 taps), >=1
// PORTS
//  clk_clk      in   1               single clock, rising edge
//  reset_reset  in   1               asynchronous, active-high reset
//  in_valid     in   1               input sample valid
//  in_ready     out  1               block can accept a sample
//  in_data      in   NUM_CH*DATA_W   packed signed samples, ch0 in [DATA_W-1:0]
//  bypass       in   1               sampled with in_data; 1 = output raw sample
//  flush        in   1               synchronous window clear, 1-cycle pulse
//  out_valid    out  1               1-cycle pulse, out_data updated
//  out_data     out  NUM_CH*DATA_W   packed signed result, held between pulses
//  primed       out  1               window holds DEPTH samples since reset/flush
// BEHAVIOUR
//  Reset values: in_ready=0 while reset is asserted, then 1 in IDLE; out_valid=0; out_data=0; primed=0.
//  Reset also clears sums, wptr, fill count and FSM state. Buffer RAM contents are not cleared.
//  FSM states:
//   IDLE: in_ready=1. If in_valid, capture in_data and bypass, set ch=0, go to PROC.
//   PROC: one channel per cycle, old = (fill<DEPTH) ? 0 : buf[ch][wptr].
//         sum[ch] <= sum[ch] - old + new[ch]; buf[ch][wptr] <= new[ch]; ch++.
//         After ch=NUM_CH-1, go to DONE.
//   DONE: out_data[ch] = bypass_q ? new[ch] : sum[ch] >>> LOG2_DEPTH (arithmetic shift, floor toward -inf).
//         out_valid=1 for this one cycle. wptr <= wptr+1 (wraps mod DEPTH); fill saturates at DEPTH.
//         primed=1 once fill reaches DEPTH. Go to IDLE.
//  Latency: capture at edge T -> out_valid high in cycle T+NUM_CH+1.
//  Throughput: at most 1 sample per NUM_CH+2 cycles. in_ready is low in PROC and DONE; input is not buffered.
//  Width: sum[ch] is DATA_W+LOG2_DEPTH bits signed and cannot overflow. The shifted result fits DATA_W exactly.
//  Bypass still updates buffer, sums, wptr and fill, so the window stays continuous.
//  Flush:
//   - Clears sums, wptr, fill and primed; FSM goes to IDLE.
//   - Flush in PROC/DONE aborts the sample with no out_valid.
//   - Flush and in_valid in the same cycle: flush wins, the sample is not accepted, and in_ready reads 0 that cycle.
//   - out_data keeps its last value.
//  Reset asserted mid-operation: immediate return to reset state; no out_valid is generated.
// TESTING
//  T1 reset: assert reset_reset asynchronously mid-PROC -> out_valid=0, out_data=0, primed=0 immediately;
//     in_ready=1 on the first cycle after release.
//  T2 ramp: 8 samples of 100 on all ch, defaults -> outputs 12,25,37,50,62,75,87,100; primed rises with 8th out_valid.
//  T3 sign: single sample ch0=-3, ch1=+3 after reset -> ch0=-1, ch1=0; out_valid exactly 4 cycles after capture edge.
//  T4 wrap: 8x(800) then 1x(0) -> 9th out=700, 16th out=0; primed stays 1.
//  T5 bypass: primed window of 800, sample 40 with bypass=1 -> out 40.
//     Next sample 0, bypass=0 -> out (6*800+40)/8 = 605.
//  T6 flush: pulse flush during PROC -> no out_valid, primed=0; next sample 80 -> out 10.
//  T7 backpressure: hold in_valid=1 with changing data -> exactly one capture per NUM_CH+2 cycles, none dropped or duplicated.

Source files
------------

// File: rtl/accel_avg_filter.sv
// accel_avg_filter
//   Multi-channel moving-average filter for raw accelerometer samples.
//   One packed NUM_CH-channel sample is accepted per handshake. Channels are
//   then folded into their running sums one per cycle through a single shared
//   adder. The output is the per-channel mean over the last 2^LOG2_DEPTH samples.
//
// Ports
//   clk_clk      : clock, rising edge
//   reset_reset  : asynchronous active-high reset
//   in_valid     : input sample valid
//   in_ready     : high in IDLE, low during reset and on a flush cycle
//   in_data      : packed signed samples, ch0 in [DATA_W-1:0]
//   bypass       : captured with in_data; 1 = output the raw sample
//   flush        : 1-cycle synchronous window clear, aborts any sample in flight
//   out_valid    : 1-cycle pulse; out_data updated on the same edge
//   out_data     : packed signed results, held between pulses
//   primed       : window holds DEPTH samples since reset/flush
module accel_avg_filter #(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     bypass,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     primed
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LOG2_DEPTH:0]  DEPTH_F = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [CH_W-1:0]      LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [LOG2_DEPTH-1:0]      wptr_q, wptr_d;
    logic [LOG2_DEPTH:0]        fill_q, fill_d;
    logic [NUM_CH*DATA_W-1:0]   samp_q, samp_d;
    logic                       byp_q, byp_d;
    logic signed [SUM_W-1:0]    sum_q [NUM_CH];
    logic signed [SUM_W-1:0]    sum_d [NUM_CH];
    logic                       out_valid_q, out_valid_d;
    logic [NUM_CH*DATA_W-1:0]   out_data_q, out_data_d;
    logic                       primed_q, primed_d;

    // Sample history; deliberately not reset, the fill count masks stale taps.
    logic signed [DATA_W-1:0]   buf_mem [NUM_CH][DEPTH];

    logic signed [DATA_W-1:0]   new_s, old_s;
    logic                       mem_we;
    logic signed [SUM_W-1:0]    sh;

    assign in_ready  = (state_q == S_IDLE) && !flush && !reset_reset;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign primed    = primed_q;

    assign new_s  = samp_q[ch_q*DATA_W +: DATA_W];
    // Until the window is full the tap being replaced is logically zero.
    assign old_s  = (fill_q < DEPTH_F) ? '0 : buf_mem[ch_q][wptr_q];
    assign mem_we = (state_q == S_PROC) && !flush;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        samp_d      = samp_q;
        byp_d       = byp_q;
        sum_d       = sum_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        primed_d    = primed_q;
        sh          = '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    samp_d  = in_data;
                    byp_d   = bypass;
                    ch_d    = '0;
                    state_d = S_PROC;
                end
            end
            S_PROC: begin
                sum_d[ch_q] = sum_q[ch_q] - SUM_W'(old_s) + SUM_W'(new_s);
                ch_d        = ch_q + 1'b1;
                if (ch_q == LAST_CH) state_d = S_DONE;
            end
            S_DONE: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    // >>> on the signed sum floors toward -inf; the mean fits DATA_W.
                    sh = sum_q[c] >>> LOG2_DEPTH;
                    out_data_d[c*DATA_W +: DATA_W] =
                        byp_q ? samp_q[c*DATA_W +: DATA_W] : sh[DATA_W-1:0];
                end
                out_valid_d = 1'b1;
                wptr_d      = wptr_q + 1'b1;
                fill_d      = (fill_q == DEPTH_F) ? fill_q : fill_q + 1'b1;
                primed_d    = (fill_d == DEPTH_F);
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything except out_data, which keeps its last value.
        if (flush) begin
            for (int c = 0; c < NUM_CH; c++) sum_d[c] = '0;
            wptr_d      = '0;
            fill_d      = '0;
            primed_d    = 1'b0;
            ch_d        = '0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            samp_q      <= '0;
            byp_q       <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            primed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            samp_q      <= samp_d;
            byp_q       <= byp_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            primed_q    <= primed_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (mem_we) buf_mem[ch_q][wptr_q] <= new_s;
    end

endmodule

// File: tb/tb_accel_avg_filter.sv
module tb_accel_avg_filter;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int L2D = 3;
    localparam int DEP = 1 << L2D;
    localparam int PW  = NCH * DW;

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_data = '0;
    logic          bypass = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          primed;

    accel_avg_filter #(.NUM_CH(NCH), .DATA_W(DW), .LOG2_DEPTH(L2D)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .bypass(bypass), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .primed(primed)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model: explicit window of past samples ----------------
    int win [NCH][$];

    function automatic logic [PW-1:0] pack3(input int a, input int b, input int c);
        logic [PW-1:0] p;
        p = '0;
        p[0*DW +: DW] = a[DW-1:0];
        p[1*DW +: DW] = b[DW-1:0];
        p[2*DW +: DW] = c[DW-1:0];
        return p;
    endfunction

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) win[c].delete();
    endtask

    task automatic model_step(input logic [PW-1:0] din, input bit byp,
                              output logic [PW-1:0] exp, output bit p);
        logic signed [DW-1:0] v;
        int s;
        exp = '0;
        for (int c = 0; c < NCH; c++) begin
            v = din[c*DW +: DW];
            win[c].push_back(int'(v));
            if (win[c].size() > DEP) void'(win[c].pop_front());
            s = 0;
            foreach (win[c][i]) s += win[c][i];
            if (byp) exp[c*DW +: DW] = v;
            else begin
                s = floor_div(s, DEP);
                exp[c*DW +: DW] = s[DW-1:0];
            end
        end
        p = (win[0].size() == DEP);
    endtask

    // ---------------- driver ----------------
    task automatic xfer(input logic [PW-1:0] din, input bit byp, input string nm,
                        output logic [PW-1:0] got, output bit gotp);
        int k;
        bit rdy;
        got = '0; gotp = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_clk);
            if (in_ready) begin rdy = 1'b1; break; end
        end
        if (!rdy) begin
            chk({nm, " ready timeout"}, 0, 1);
            return;
        end
        in_valid = 1'b1; in_data = din; bypass = byp;
        @(posedge clk_clk); #1;
        in_valid = 1'b0; bypass = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) begin @(posedge clk_clk); #1; end
            else begin @(posedge clk_clk); #1; end
            if (out_valid) begin k = i; break; end
        end
        chk({nm, " latency"}, k, NCH + 1);
        got  = out_data;
        gotp = primed;
    endtask

    task automatic run(input logic [PW-1:0] din, input bit byp, input string nm,
                       output logic [PW-1:0] got);
        logic [PW-1:0] exp;
        bit ep, gp;
        model_step(din, byp, exp, ep);
        xfer(din, byp, nm, got, gp);
        chk({nm, " data"}, got, exp);
        chk({nm, " primed"}, gp, ep);
    endtask

    task automatic do_flush();
        @(negedge clk_clk); flush = 1'b1;
        @(negedge clk_clk); flush = 1'b0;
        model_clear();
    endtask

    task automatic count_outs(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_clk); #1;
            if (out_valid) cnt++;
        end
    endtask

    typedef struct {
        logic [PW-1:0] din;
        bit            byp;
        int            exp;
        bit            exp_p;
    } vec_t;

    vec_t ramp [DEP];

    initial begin
        logic [PW-1:0] got, exp;
        bit ep;
        int cnt, last_cap;
        logic [PW-1:0] expq [$];
        int ramp_exp [DEP] = '{12, 25, 37, 50, 62, 75, 87, 100};

        for (int i = 0; i < DEP; i++) begin
            ramp[i].din   = pack3(100, 100, 100);
            ramp[i].byp   = 1'b0;
            ramp[i].exp   = ramp_exp[i];
            ramp[i].exp_p = (i == DEP - 1);
        end

        // reset state
        #12;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst primed", primed, 0);
        @(negedge clk_clk); reset_reset = 1'b0;
        @(posedge clk_clk); #1;
        chk("post-rst in_ready", in_ready, 1);
        model_clear();

        // T2 ramp, table-driven
        for (int i = 0; i < DEP; i++) begin
            run(ramp[i].din, ramp[i].byp, $sformatf("ramp%0d", i), got);
            chk($sformatf("ramp%0d const", i), got, pack3(ramp[i].exp, ramp[i].exp, ramp[i].exp));
            chk($sformatf("ramp%0d primed const", i), primed, ramp[i].exp_p);
        end

        // T4 wrap
        do_flush();
        chk("flush primed", primed, 0);
        for (int i = 0; i < DEP; i++) run(pack3(800, 800, 800), 0, "fill800", got);
        run(pack3(0, 0, 0), 0, "wrap9", got);
        chk("wrap9 const", got, pack3(700, 700, 700));
        for (int i = 0; i < DEP - 1; i++) run(pack3(0, 0, 0), 0, "wrap0", got);
        chk("wrap16 const", got, pack3(0, 0, 0));
        chk("wrap16 primed", primed, 1);

        // T5 bypass
        do_flush();
        for (int i = 0; i < DEP; i++) run(pack3(800, 800, 800), 0, "b800", got);
        run(pack3(40, 40, 40), 1, "byp", got);
        chk("byp const", got, pack3(40, 40, 40));
        run(pack3(0, 0, 0), 0, "post-byp", got);
        chk("post-byp const", got, pack3(605, 605, 605));

        // T1 reset mid-PROC (window primed, out_data nonzero beforehand)
        @(negedge clk_clk); in_valid = 1'b1; in_data = pack3(5, 5, 5);
        @(posedge clk_clk); #1; in_valid = 1'b0;
        @(posedge clk_clk); #2; reset_reset = 1'b1;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_data", out_data, 0);
        chk("midrst primed", primed, 0);
        chk("midrst in_ready", in_ready, 0);
        @(negedge clk_clk); reset_reset = 1'b0;
        @(posedge clk_clk); #1;
        chk("midrst in_ready after", in_ready, 1);
        count_outs(8, cnt);
        chk("midrst no out", cnt, 0);
        model_clear();

        // T3 sign
        run(pack3(-3, 3, 0), 0, "sign", got);
        chk("sign const", got, pack3(-1, 0, 0));

        // T6 flush during PROC
        for (int i = 0; i < DEP - 1; i++) run(pack3(64, -64, 7), 0, "pre6", got);
        @(negedge clk_clk); in_valid = 1'b1; in_data = pack3(64, 64, 64);
        @(posedge clk_clk); #1; in_valid = 1'b0; flush = 1'b1;
        @(posedge clk_clk); #1; flush = 1'b0;
        count_outs(10, cnt);
        chk("flush abort no out", cnt, 0);
        chk("flush abort primed", primed, 0);
        model_clear();
        run(pack3(80, 80, 80), 0, "after-flush", got);
        chk("after-flush const", got, pack3(10, 10, 10));

        // flush and in_valid together: flush wins
        @(negedge clk_clk); in_valid = 1'b1; flush = 1'b1; in_data = pack3(9, 9, 9);
        #1;
        chk("flush+valid in_ready", in_ready, 0);
        @(posedge clk_clk); #1; in_valid = 1'b0; flush = 1'b0;
        count_outs(8, cnt);
        chk("flush+valid no out", cnt, 0);
        model_clear();

        // T7 backpressure: in_valid held, data changing every cycle
        last_cap = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk_clk);
            in_valid = 1'b1;
            in_data  = pack3($urandom_range(0, 2000) - 1000, cyc, -cyc);
            if (in_ready) begin
                if (last_cap >= 0) chk("bp interval", cyc - last_cap, NCH + 2);
                last_cap = cyc;
                model_step(in_data, 0, exp, ep);
                expq.push_back(exp);
            end
            @(posedge clk_clk); #1;
            if (out_valid) begin
                if (expq.size() == 0) chk("bp spurious out", 1, 0);
                else chk("bp data", out_data, expq.pop_front());
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_clk); #1;
            if (out_valid) begin
                if (expq.size() == 0) chk("bp spurious out", 1, 0);
                else chk("bp data", out_data, expq.pop_front());
            end
        end
        chk("bp all drained", expq.size(), 0);

        // randomized
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            run(pack3($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                      $urandom_range(0, 65535) - 32768),
                ($urandom_range(0, 4) == 0), $sformatf("rnd%0d", i), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
